// File: rtl/pool_flatten_engine.sv
`default_nettype none
// ============================================================================
// Module      : pool_flatten_engine
// Description : KxK max/average pooling over CH channel memories read through
//               a shared crd/caddr_rd/csel port. Each pooled value goes to a
//               per-channel output memory and, when the POOL_FLATTEN_EN macro
//               is defined, also to an interleaved flatten memory.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_flatten_engine #(
  parameter int unsigned IMG_W    = 64,
  parameter int unsigned IMG_H    = 64,
  parameter int unsigned DW       = 20,
  parameter int unsigned CH       = 2,
  parameter int unsigned K        = 2,
  parameter int unsigned AW       = 12,
  parameter int unsigned SRC_SEL  = 1,
  parameter int unsigned DST_SEL  = 3,
  parameter int unsigned FLAT_SEL = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic [2:0]    csel,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr
);

  localparam int unsigned LK    = $clog2(K);
  localparam int unsigned KK    = K * K;
  localparam int unsigned OW    = IMG_W / K;
  localparam int unsigned OH    = IMG_H / K;
  localparam int unsigned SH    = 2 * LK;
  localparam int unsigned ACC_W = DW + SH;
  localparam int unsigned KW    = 5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LAST = 3'd2,
    S_WR   = 3'd3,
`ifdef POOL_FLATTEN_EN
    S_FLAT = 3'd4,
`endif
    S_FIN  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [2:0]         c_q, c_d;
  logic [AW-1:0]      oy_q, oy_d;
  logic [AW-1:0]      ox_q, ox_d;
  logic [KW-1:0]      k_q, k_d;
  logic [ACC_W-1:0]   acc_q, acc_d;

  logic               last_ox, last_oy, last_c;
  logic               win_end;
  state_t             next_win_state;
  logic               fold_en, fold_first;
  logic [ACC_W-1:0]   pix_ext;
  logic [AW-1:0]      dy_a, dx_a;
  logic [AW-1:0]      rd_addr, wr_addr;
  logic [DW-1:0]      pooled;

  assign last_ox = (ox_q == AW'(OW - 1));
  assign last_oy = (oy_q == AW'(OH - 1));
  assign last_c  = (c_q == 3'(CH - 1));
  assign next_win_state = (last_ox && last_oy && last_c) ? S_FIN : S_RD;

  // The window is finished after its final write cycle.
`ifdef POOL_FLATTEN_EN
  assign win_end = (state_q == S_FLAT);
`else
  assign win_end = (state_q == S_WR);
`endif

  // Read data trails crd by one cycle: sample n is folded in while sample n+1
  // is being requested, and the last sample is folded in during LAST.
  assign fold_en    = ((state_q == S_RD) && (k_q != '0)) || (state_q == S_LAST);
  assign fold_first = (state_q == S_RD) && (k_q == KW'(1));
  assign pix_ext    = {{SH{cdata_rd[DW-1]}}, cdata_rd};

  // Window pixel address, row-major within the window.
  assign dy_a    = AW'(k_q >> LK);
  assign dx_a    = AW'(k_q & KW'(K - 1));
  assign rd_addr = ((oy_q << LK) + dy_a) * AW'(IMG_W) + (ox_q << LK) + dx_a;
  assign wr_addr = oy_q * AW'(OW) + ox_q;

  // Average: top DW bits of the sum equal an arithmetic shift by 2*LK (floor).
  assign pooled = mode_q ? acc_q[ACC_W-1:SH] : acc_q[DW-1:0];

  // Next-state, traversal counters and accumulator update.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    c_d     = c_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    k_d     = k_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          c_d     = '0;
          oy_d    = '0;
          ox_d    = '0;
          k_d     = '0;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (k_q == KW'(KK - 1)) begin
          k_d     = '0;
          state_d = S_LAST;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_LAST: state_d = S_WR;
`ifdef POOL_FLATTEN_EN
      S_WR:   state_d = S_FLAT;
      S_FLAT: state_d = next_win_state;
`else
      S_WR:   state_d = next_win_state;
`endif
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // ox innermost, then oy, channel outermost.
    if (win_end) begin
      if (last_ox) begin
        ox_d = '0;
        if (last_oy) begin
          oy_d = '0;
          c_d  = c_q + 3'd1;
        end else begin
          oy_d = oy_q + AW'(1);
        end
      end else begin
        ox_d = ox_q + AW'(1);
      end
    end

    if (fold_en) begin
      if (fold_first) begin
        acc_d = pix_ext;
      end else if (mode_q) begin
        acc_d = acc_q + pix_ext;
      end else if ($signed(pix_ext) > $signed(acc_q)) begin
        acc_d = pix_ext;
      end
    end
  end

  // Memory-port outputs decoded from the current state; zero when idle.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    crd      = 1'b0;
    cwr      = 1'b0;
    csel     = 3'd0;
    caddr_rd = '0;
    caddr_wr = '0;
    cdata_wr = '0;
    case (state_q)
      S_RD: begin
        busy     = 1'b1;
        crd      = 1'b1;
        csel     = 3'(SRC_SEL) + c_q;
        caddr_rd = rd_addr;
      end
      S_LAST: busy = 1'b1;
      S_WR: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        csel     = 3'(DST_SEL) + c_q;
        caddr_wr = wr_addr;
        cdata_wr = pooled;
      end
`ifdef POOL_FLATTEN_EN
      S_FLAT: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        csel     = 3'(FLAT_SEL);
        caddr_wr = wr_addr * AW'(CH) + AW'(c_q);
        cdata_wr = pooled;
      end
`endif
      S_FIN: done = 1'b1;
      default: ;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      c_q     <= '0;
      oy_q    <= '0;
      ox_q    <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      oy_q    <= oy_d;
      ox_q    <= ox_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pool_flatten_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_flatten_engine
// Description : Self-checking bench for pool_flatten_engine on a 7x5 image
//               (trailing column and row are never pooled), CH=2, K=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_flatten_engine;

  localparam int IMG_W = 7;
  localparam int IMG_H = 5;
  localparam int DW    = 20;
  localparam int CH    = 2;
  localparam int K     = 2;
  localparam int AW    = 8;
  localparam int SRC   = 1;
  localparam int DST   = 3;
  localparam int FLATS = 5;
  localparam int OW    = IMG_W / K;
  localparam int OH    = IMG_H / K;
  localparam int NWIN  = CH * OW * OH;
`ifdef POOL_FLATTEN_EN
  localparam int WCYC  = K * K + 3;
  localparam int NWR   = 2;
`else
  localparam int WCYC  = K * K + 2;
  localparam int NWR   = 1;
`endif
  localparam int BUDGET = 2 * NWIN * WCYC + 50;

  logic          clk = 1'b0;
  logic          reset, start, mode;
  logic          busy, done, crd, cwr;
  logic [AW-1:0] caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd, cdata_wr;
  logic [2:0]    csel;

  pool_flatten_engine #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .CH(CH), .K(K), .AW(AW),
    .SRC_SEL(SRC), .DST_SEL(DST), .FLAT_SEL(FLATS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .done(done), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(cdata_rd), .csel(csel), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [8][256];
  logic [DW-1:0] src [CH][IMG_W*IMG_H];
  int cyc = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, viol = 0;
  int errors = 0, checks = 0;

  // Memory model plus protocol monitor.
  always @(posedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (crd) begin
      rd_cnt++;
      cdata_rd <= mem[csel][caddr_rd];
      if (int'(csel) < SRC || int'(csel) >= SRC + CH) viol++;
      if (int'(caddr_rd) % IMG_W >= OW * K || int'(caddr_rd) / IMG_W >= OH * K) viol++;
    end
    if (cwr) begin
      wr_cnt++;
      mem[csel][caddr_wr] <= cdata_wr;
`ifdef POOL_FLATTEN_EN
      if (!((int'(csel) >= DST && int'(csel) < DST + CH) || int'(csel) == FLATS)) viol++;
`else
      if (!(int'(csel) >= DST && int'(csel) < DST + CH)) viol++;
`endif
    end
    if (crd && cwr) viol++;
    if (!crd && !cwr && csel != 3'd0) viol++;
`ifndef POOL_FLATTEN_EN
    if (int'(csel) == FLATS) viol++;
`endif
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: max or floor(sum/K^2) over the window, in plain integers.
  function automatic logic [DW-1:0] ref_pool(int c, int oy, int ox, bit m);
    logic signed [DW-1:0] p;
    int v, best, sum, q;
    logic [31:0] r;
    best = 0; sum = 0;
    for (int dy = 0; dy < K; dy++)
      for (int dx = 0; dx < K; dx++) begin
        p = src[c][(oy*K+dy)*IMG_W + ox*K + dx];
        v = p;
        sum += v;
        if ((dy == 0 && dx == 0) || v > best) best = v;
      end
    q = sum / (K*K);
    if (sum < 0 && (sum % (K*K)) != 0) q = q - 1;
    r = m ? q : best;
    return r[DW-1:0];
  endfunction

  // kind 0 random, 1 ramp (pixel index), 2 random negative
  task automatic fill(input int c, input int kind);
    logic [DW-1:0] v;
    for (int a = 0; a < IMG_W*IMG_H; a++) begin
      v = DW'($urandom);
      if (kind == 1) v = DW'(a);
      if (kind == 2) v = v | 20'h80000;
      src[c][a] = v;
      mem[SRC+c][a] = v;
    end
  endtask

  task automatic poke_px(input int a, input logic [DW-1:0] v);
    src[0][a] = v;
    mem[SRC][a] = v;
  endtask

  task automatic clear_outputs();
    for (int a = 0; a < NWIN; a++) begin
      mem[FLATS][a] = 20'hAAAAA;
      for (int c = 0; c < CH; c++) mem[DST+c][a] = 20'hAAAAA;
    end
  endtask

  task automatic check_results(input bit m, input string tag);
    for (int c = 0; c < CH; c++)
      for (int oy = 0; oy < OH; oy++)
        for (int ox = 0; ox < OW; ox++) begin
          check($sformatf("%s_pool_c%0d_y%0d_x%0d", tag, c, oy, ox),
                64'(mem[DST+c][oy*OW+ox]), 64'(ref_pool(c, oy, ox, m)));
`ifdef POOL_FLATTEN_EN
          check($sformatf("%s_flat_c%0d_y%0d_x%0d", tag, c, oy, ox),
                64'(mem[FLATS][(oy*OW+ox)*CH+c]), 64'(ref_pool(c, oy, ox, m)));
`endif
        end
  endtask

  // Starts a job at the current negedge; optionally re-pulses start with a
  // flipped mode at loop step 'poke'. Returns with the bench in IDLE.
  task automatic run_job(input bit m, input int poke, input string tag);
    int s, lat, d0, w0;
    lat = -1;
    d0 = done_cnt; w0 = wr_cnt;
    clear_outputs();
    start = 1'b1; mode = m; s = cyc;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_crd_after_start"}, 64'({busy, crd}), 64'b11);
    for (int i = 0; i < BUDGET; i++) begin
      if (done) begin lat = cyc - s; break; end
      start = (i == poke);
      if (i == poke) mode = ~m;
      @(negedge clk);
    end
    start = 1'b0;
    // start cycle and done cycle inclusive: 1 + NWIN*WCYC + 1 cycles
    check({tag, "_job_length"}, 64'(lat + 1), 64'(2 + NWIN * WCYC));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'({done, busy}), 64'b00);
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_write_count"}, 64'(wr_cnt - w0), 64'(NWIN * NWR));
    check_results(m, tag);
  endtask

  initial begin
    int wc, rc;
    reset = 1'b0; start = 1'b0; mode = 1'b0;
    for (int a = 0; a < 256; a++)
      for (int s = 0; s < 8; s++) mem[s][a] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_outputs", 64'({busy, done, crd, cwr, csel}), 64'd0);

    // Max on a ramp channel and a random channel.
    fill(0, 1); fill(1, 0);
    run_job(1'b0, -1, "max_ramp");

    // Back-to-back average job; start/mode disturbed mid-job.
    fill(0, 0); fill(1, 0);
    run_job(1'b1, 10, "avg_rand_poke");

    // Directed windows: {1,2,3,4} and {-8,-3,-5,-1}; channel 1 all negative.
    fill(0, 0); fill(1, 2);
    poke_px(0, 20'd1);       poke_px(1, 20'd2);
    poke_px(IMG_W, 20'd3);   poke_px(IMG_W+1, 20'd4);
    poke_px(2, 20'hFFFF8);   poke_px(3, 20'hFFFFD);
    poke_px(IMG_W+2, 20'hFFFFB); poke_px(IMG_W+3, 20'hFFFFF);
    run_job(1'b1, -1, "avg_dir");
    check("avg_window_1234", 64'(mem[DST][0]), 64'd2);
    check("avg_window_neg", 64'(mem[DST][1]), 64'h0FFFFB);
    run_job(1'b0, -1, "max_dir");
    check("max_window_neg", 64'(mem[DST][1]), 64'h0FFFFF);

    // Reset mid-job.
    fill(0, 0); fill(1, 0);
    clear_outputs();
    start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    wc = wr_cnt; rc = rd_cnt;
    reset = 1'b0;
    #1;
    check("midjob_reset_outputs", 64'({busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}), 64'd0);
    repeat (4) @(negedge clk);
    check("midjob_reset_no_write", 64'(wr_cnt - wc), 64'd0);
    check("midjob_reset_no_read", 64'(rd_cnt - rc), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 64'({busy, done}), 64'd0);
    fill(0, 2); fill(1, 0);
    run_job(1'b0, -1, "after_reset");

    check("protocol_violations", 64'(viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pool_flatten_engine.md
# pool_flatten_engine

Parametrised pooling engine for the CNN accelerator. It reads CH convolution-output channel memories through the shared `crd`/`caddr_rd`/`csel` port and computes K×K max or average pooling per channel. Results go to per-channel pooled memories and, optionally, to an interleaved flatten memory. It sits behind the layer-0 convolution stage and generalises the fixed 2×2, 2-channel, max-only layer-1/layer-2 path.

## Interface
- `IMG_W`, 64: input image width in pixels.
- `IMG_H`, 64: input image height in pixels.
- `DW`, 20: pixel width, signed two's complement.
- `CH`, 2: number of channels, range 1–4.
- `K`, 2: pool window edge, either 2 or 4. Derived values: `LK` = log2(`K`), `OW` = `IMG_W`/`K`, `OH` = `IMG_H`/`K`, both floored.
- `AW`, 12: address width. Must be ≥ clog2(max(`IMG_W`·`IMG_H`, `CH`·`OW`·`OH`)).
- `SRC_SEL`, 1: `csel` code of input channel 0. Channel c uses `SRC_SEL`+c.
- `DST_SEL`, 3: `csel` code of pooled output channel 0. Channel c uses `DST_SEL`+c.
- `FLAT_SEL`, 5: `csel` code of the flatten memory.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: starts a job; only honoured while idle.
- `mode` in 1: 0 selects max, 1 selects average. Sampled together with `start`.
- `busy` out 1: high while a job is running.
- `done` out 1: one-cycle pulse at job completion.
- `crd` out 1: read strobe.
- `caddr_rd` out `AW`: read address.
- `cdata_rd` in `DW`: read data, valid one cycle after `crd`.
- `csel` out 3: memory select, shared by reads and writes.
- `cwr` out 1: write strobe, sampled by the memory at the rising edge.
- `caddr_wr` out `AW`: write address.
- `cdata_wr` out `DW`: write data.

## Operation
- **Reset values:** `busy`, `done`, `crd`, `cwr`, `caddr_rd`, `caddr_wr`, `cdata_wr` and `csel` are all 0. The FSM is in IDLE.
- **FSM states:** IDLE → RD → LAST → WR → [FLAT] → (next window: RD | finished: FIN) → IDLE.
- **IDLE:** when `start` is 1, latch `mode`, clear counters c/oy/ox, go to RD, set `busy`=1.
- **RD:** lasts K·K cycles.
  - `crd`=1, `csel`=`SRC_SEL`+c.
  - Window pixels are read row-major (dy outer, dx inner).
  - `caddr_rd` = (oy·K+dy)·`IMG_W` + ox·K + dx.
  - Data returned one cycle later is folded into the accumulator. The first sample loads the accumulator; later samples combine with it.
- **LAST:** lasts one cycle. `crd`=0 and the final sample is folded in.
- **WR:** lasts one cycle.
  - `cwr`=1, `csel`=`DST_SEL`+c.
  - `caddr_wr` = oy·`OW`+ox.
  - `cdata_wr` = pooled result.
- **FLAT:** present only with the macro (see Configuration). `cwr`=1, `csel`=`FLAT_SEL`, `caddr_wr` = (oy·`OW`+ox)·`CH`+c, same data as WR.
- **Traversal order:** ox innermost, then oy, then c outermost.
  - After the final window (c=`CH`−1, oy=`OH`−1, ox=`OW`−1), go to FIN.
  - In FIN: `busy`=0, `done`=1 for one cycle, then IDLE.
- **Max mode:**
  - Signed compare. On a tie, either operand may be kept (the values are equal).
  - An all-negative window yields its largest (least negative) value.
- **Average mode:**
  - Accumulator is `DW`+2·`LK` bits, sign-extended.
  - Result = accumulator >>> 2·`LK` (arithmetic shift, floor toward −∞), truncated to `DW` bits. The truncation is lossless.
- **Edge pixels:** trailing columns or rows beyond `OW`·`K` or `OH`·`K` are never read.
- **Strobes:** `crd` and `cwr` are never high in the same cycle. `csel` always matches the active strobe and is 0 when both strobes are low.
- **Start while busy:** `start` is ignored and `mode` is not re-latched.
- **Reset mid-job:** everything returns to reset values immediately. No further reads or writes occur, and the partial job is discarded.

## Timing
- **Cycles per window:** K·K+2 without the macro, K·K+3 with it.
- **Job length:** from the `start` cycle to the `done` cycle is 1 + `CH`·`OW`·`OH`·(cycles per window) + 1 cycles.
- **Default parameters, K=2, no flatten:** 2·1024·6 + 2 = 12290 cycles.
- **Start to first read:** `busy` and the first `crd` assert in the cycle after `start` is sampled.
- **Back-to-back jobs:** `start` may be sampled again in the cycle after `done`.
- **Memory read protocol:** the memory samples `crd`/`caddr_rd` and drives `cdata_rd` before the next rising edge. The engine captures it at that edge.

## Configuration
- **`POOL_FLATTEN_EN` defined:** the FLAT state exists and every pooled value is also written interleaved to `FLAT_SEL`. Per window costs K·K+3 cycles.
- **`POOL_FLATTEN_EN` undefined:** the FLAT state and its address logic are not compiled. `csel` never equals `FLAT_SEL`. Per window costs K·K+2 cycles.

## Test plan
- **Max, 4×4 ramp:** `IMG_W`=`IMG_H`=4, `CH`=2, K=2, `mode`=0, channel 0 pixel = index 0..15.
  - Required: DST ch0 = {5, 7, 13, 15}. `done` in cycle 1 + 2·4·6 + 1 = 50 after `start`.
- **Average, single window:** window {1,2,3,4} → 2. Window {−8,−3,−5,−1} → floor(−17/4) = −5 = 20'hFFFFB. Max mode on the same negative window → 20'hFFFFF.
- **Flatten addressing:** `POOL_FLATTEN_EN` defined, `CH`=2, 4×4 image.
  - Required: channel 0 window (oy=1, ox=0) written to `FLAT_SEL` address 4; channel 1 same window to address 5.
  - Required: `csel` never equals 5 when the macro is undefined.
- **Handshake:** pulse `start` and toggle `mode` mid-job. Required: no restart, the latched mode is kept, and exactly one `done` pulse.
- **Reset mid-job:** assert `reset` low mid-job. Required: all outputs 0 in the same cycle and no `cwr` afterwards. After release, a new `start` completes correctly.
- **Full-size regression:** 64×64, `CH`=2, K=2, max mode, with `POOL_FLATTEN_EN` defined, using the layer-0 data set.
  - Required: pooled outputs match the layer-1 expected data. Flatten output matches the layer-2 expected data. Zero errors.
